// File: rtl/debug_module.sv
// RISC-V external debug module for a single hart: DMI register access plus halt/resume/reset controls.
// Optional haltsum0 register at 0x40 is built when DM_HALTSUM_EN is defined.
module debug_module (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dmi_start,
    input  logic [1:0]  dmi_op,
    input  logic [6:0]  dmi_address,
    input  logic [31:0] dmi_data_o,
    output logic [31:0] dmi_data_i,
    output logic        dmi_finish,
    input  logic        halted,
    input  logic        running,
    output logic        haltreq,
    output logic        resumereq,
    output logic        resethaltreq,
    output logic        ndmreset
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_DONE
    } state_t;

    state_t      state;
    logic        start_q;
    logic [1:0]  op_q;
    logic [6:0]  addr_q;
    logic [31:0] wdata_q;
    logic        dmactive;
    logic        resumeack;
    logic [31:0] rdata;

    always_comb begin
        rdata = '0;
        case (addr_q)
            7'h10: rdata = {30'b0, ndmreset, dmactive};
            7'h11: rdata = {14'b0, resumeack, resumeack, 4'b0,
                            running, running, halted, halted,
                            1'b1, 3'b0, 4'd2};
`ifdef DM_HALTSUM_EN
            7'h40: rdata = {31'b0, halted};
`endif
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            start_q      <= 1'b0;
            op_q         <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            dmi_data_i   <= '0;
            dmi_finish   <= 1'b0;
            haltreq      <= 1'b0;
            resumereq    <= 1'b0;
            resethaltreq <= 1'b0;
            ndmreset     <= 1'b0;
            dmactive     <= 1'b0;
            resumeack    <= 1'b0;
        end else begin
            start_q <= dmi_start;

            if (resumereq && running && !halted) begin
                resumereq <= 1'b0;
                resumeack <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (dmi_start && !start_q) begin
                        op_q    <= dmi_op;
                        addr_q  <= dmi_address;
                        wdata_q <= dmi_data_o;
                        state   <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    dmi_finish <= 1'b1;
                    state      <= ST_DONE;
                    if (op_q == 2'd1) begin
                        dmi_data_i <= rdata;
                    end
                    // Placed after the running-based clear so a resume write wins the same cycle.
                    if (op_q == 2'd2 && addr_q == 7'h10) begin
                        haltreq  <= wdata_q[31];
                        ndmreset <= wdata_q[1];
                        dmactive <= wdata_q[0];
                        if (wdata_q[30] && !wdata_q[31]) begin
                            resumereq <= 1'b1;
                            resumeack <= 1'b0;
                        end
                        if (wdata_q[2]) begin
                            resethaltreq <= 1'b0;
                        end else if (wdata_q[3]) begin
                            resethaltreq <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (!dmi_start) begin
                        dmi_finish <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_debug_module.sv
// Directed self-checking bench for debug_module: DMI handshake, dmcontrol/dmstatus and reset behaviour.
module tb_debug_module;

    logic        clk;
    logic        rst_n;
    logic        dmi_start;
    logic [1:0]  dmi_op;
    logic [6:0]  dmi_address;
    logic [31:0] dmi_data_o;
    logic [31:0] dmi_data_i;
    logic        dmi_finish;
    logic        halted;
    logic        running;
    logic        haltreq;
    logic        resumereq;
    logic        resethaltreq;
    logic        ndmreset;

    int vectors;
    int miscompares;

    debug_module dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .dmi_start    (dmi_start),
        .dmi_op       (dmi_op),
        .dmi_address  (dmi_address),
        .dmi_data_o   (dmi_data_o),
        .dmi_data_i   (dmi_data_i),
        .dmi_finish   (dmi_finish),
        .halted       (halted),
        .running      (running),
        .haltreq      (haltreq),
        .resumereq    (resumereq),
        .resethaltreq (resethaltreq),
        .ndmreset     (ndmreset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Full 4-phase transaction; finish must appear exactly one cycle after the request is latched.
    task automatic dmi_access(input logic [1:0] op, input logic [6:0] a, input logic [31:0] d);
        dmi_op      = op;
        dmi_address = a;
        dmi_data_o  = d;
        dmi_start   = 1'b1;
        @(posedge clk); #1;
        check("finish_latch", {31'b0, dmi_finish}, 32'd0);
        @(posedge clk); #1;
        check("finish_rise", {31'b0, dmi_finish}, 32'd1);
        dmi_start = 1'b0;
        @(posedge clk); #1;
        check("finish_drop", {31'b0, dmi_finish}, 32'd0);
    endtask

    initial begin
        logic [31:0] exp_hs;
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        dmi_start   = 1'b0;
        dmi_op      = 2'd0;
        dmi_address = '0;
        dmi_data_o  = '0;
        halted      = 1'b0;
        running     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_haltreq",      {31'b0, haltreq},      32'd0);
        check("rst_resumereq",    {31'b0, resumereq},    32'd0);
        check("rst_ndmreset",     {31'b0, ndmreset},     32'd0);
        check("rst_resethaltreq", {31'b0, resethaltreq}, 32'd0);
        check("rst_finish",       {31'b0, dmi_finish},   32'd0);
        check("rst_data",         dmi_data_i,            32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // halt request
        dmi_access(2'd2, 7'h10, 32'h8000_0000);
        check("haltreq_set", {31'b0, haltreq}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("haltreq_hold", {31'b0, haltreq}, 32'd1);

        halted = 1'b1;
        dmi_access(2'd1, 7'h11, 32'h0);
        check("dmstatus_halted", dmi_data_i, 32'h0000_0382);

        // resume ignored while haltreq is written 1
        dmi_access(2'd2, 7'h10, 32'hC000_0000);
        check("resume_ignored_hr", {31'b0, haltreq},   32'd1);
        check("resume_ignored_rr", {31'b0, resumereq}, 32'd0);

        dmi_access(2'd2, 7'h10, 32'h4000_0000);
        check("resume_haltreq",   {31'b0, haltreq},   32'd0);
        check("resume_resumereq", {31'b0, resumereq}, 32'd1);
        check("data_hold_write",  dmi_data_i,         32'h0000_0382);

        halted  = 1'b0;
        running = 1'b1;
        @(posedge clk); #1;
        check("resumereq_clear", {31'b0, resumereq}, 32'd0);
        dmi_access(2'd1, 7'h11, 32'h0);
        check("dmstatus_running", dmi_data_i, 32'h0003_0C82);

        // unmapped / read-only accesses
        dmi_access(2'd2, 7'h42, 32'hFFFF_FFFF);
        check("unmapped_wr_hr",  {31'b0, haltreq},      32'd0);
        check("unmapped_wr_nd",  {31'b0, ndmreset},     32'd0);
        check("unmapped_wr_rh",  {31'b0, resethaltreq}, 32'd0);
        dmi_access(2'd1, 7'h42, 32'h0);
        check("unmapped_rd", dmi_data_i, 32'd0);
        dmi_access(2'd2, 7'h11, 32'hFFFF_FFFF);
        dmi_access(2'd1, 7'h12, 32'h0);
        check("hartinfo_rd", dmi_data_i, 32'd0);
        dmi_access(2'd1, 7'h16, 32'h0);
        check("abstractcs_rd", dmi_data_i, 32'd0);
        halted = 1'b1;
`ifdef DM_HALTSUM_EN
        exp_hs = 32'd1;
`else
        exp_hs = 32'd0;
`endif
        dmi_access(2'd1, 7'h40, 32'h0);
        check("haltsum0_rd", dmi_data_i, exp_hs);
        halted = 1'b0;

        // ndmreset / resethaltreq
        dmi_access(2'd2, 7'h10, 32'h0000_000B);
        check("ndmreset_set", {31'b0, ndmreset},     32'd1);
        check("rhr_set",      {31'b0, resethaltreq}, 32'd1);
        dmi_access(2'd1, 7'h10, 32'h0);
        check("dmcontrol_rd_b", dmi_data_i, 32'h0000_0003);
        dmi_access(2'd2, 7'h10, 32'h0000_0005);
        check("ndmreset_clr", {31'b0, ndmreset},     32'd0);
        check("rhr_clr",      {31'b0, resethaltreq}, 32'd0);
        dmi_access(2'd1, 7'h10, 32'h0);
        check("dmcontrol_rd_5", dmi_data_i, 32'h0000_0001);
        dmi_access(2'd2, 7'h10, 32'h0000_0008);
        check("rhr_set2", {31'b0, resethaltreq}, 32'd1);
        dmi_access(2'd2, 7'h10, 32'h0000_000C);
        check("rhr_clr_wins", {31'b0, resethaltreq}, 32'd0);

        // nop and op 3 hold read data
        dmi_access(2'd0, 7'h11, 32'h0);
        check("nop_hold", dmi_data_i, 32'h0000_0001);
        dmi_access(2'd3, 7'h11, 32'h0);
        check("op3_hold", dmi_data_i, 32'h0000_0001);

        // reset mid-transaction discards the request
        dmi_op      = 2'd2;
        dmi_address = 7'h10;
        dmi_data_o  = 32'h8000_0002;
        dmi_start   = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_finish", {31'b0, dmi_finish}, 32'd0);
        dmi_start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("midrst_finish_after", {31'b0, dmi_finish}, 32'd0);
        check("midrst_haltreq",      {31'b0, haltreq},    32'd0);
        check("midrst_ndmreset",     {31'b0, ndmreset},   32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
